// File: rtl/output_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : output_stream_packer
// Description : Output stage of the feature-map pipeline. Pixel words from
//               the compute pipeline go into a small first-word-fall-through
//               skid FIFO. The FIFO asks upstream to pause one entry before
//               it is full. Words at the FIFO head are tagged with their
//               column/row position so that row and frame boundaries are
//               visible downstream.
// Ports       : clk          - single clock, rising edge
//               rst          - synchronous active-high reset
//               in_valid     - pixel word present on in_data this cycle
//               in_data      - NFMAPS x BITWIDTH pixel word (fmap 0 in LSBs)
//               stall        - pause request to upstream (count >= depth-1)
//               out_valid    - out_data holds a valid pixel word
//               out_ready    - downstream accepts the word this cycle
//               out_data     - oldest FIFO entry (zero when empty)
//               out_last_col - head word is the last pixel of its row
//               out_last_row - head word belongs to the last row of the frame
//               frame_done   - one-cycle pulse after the final frame pixel
//               overflow     - sticky: a word arrived while full and was lost
// Revision    : 1.0 - initial release
// ============================================================================
module output_stream_packer #(
   parameter int BITWIDTH   = 8,
   parameter int NFMAPS     = 3,
   parameter int OUT_X_DIM  = 32,
   parameter int OUT_Y_DIM  = 32,
   parameter int FIFO_DEPTH = 4    // power of two, >= 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   input  logic [NFMAPS*BITWIDTH-1:0] in_data,
   output logic                       stall,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NFMAPS*BITWIDTH-1:0] out_data,
   output logic                       out_last_col,
   output logic                       out_last_row,
   output logic                       frame_done,
   output logic                       overflow
);

   localparam int c_DW = NFMAPS * BITWIDTH;
   localparam int c_PW = $clog2(FIFO_DEPTH);
   localparam int c_CW = $clog2(FIFO_DEPTH) + 1;
   localparam int c_XW = (OUT_X_DIM > 1) ? $clog2(OUT_X_DIM) : 1;
   localparam int c_YW = (OUT_Y_DIM > 1) ? $clog2(OUT_Y_DIM) : 1;

   localparam logic [c_CW-1:0] c_FULL     = c_CW'(FIFO_DEPTH);
   localparam logic [c_CW-1:0] c_STALL_AT = c_CW'(FIFO_DEPTH - 1);
   localparam logic [c_XW-1:0] c_X_LAST   = c_XW'(OUT_X_DIM - 1);
   localparam logic [c_YW-1:0] c_Y_LAST   = c_YW'(OUT_Y_DIM - 1);

   // ------------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------------
   logic [c_DW-1:0] mem_q [FIFO_DEPTH];
   logic [c_DW-1:0] mem_d [FIFO_DEPTH];
   logic [c_PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_CW-1:0] count_q, count_d;
   logic [c_XW-1:0] x_q, x_d;
   logic [c_YW-1:0] y_q, y_d;
   logic            frame_done_q, frame_done_d;
   logic            overflow_q, overflow_d;

   logic w_full;
   logic w_pop;
   logic w_push;
   logic w_drop;
   logic w_x_last;
   logic w_y_last;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   assign w_full   = (count_q == c_FULL);
   assign w_pop    = out_valid && out_ready;
   // A pop in the same cycle frees the slot, so a full FIFO can still accept.
   assign w_push   = in_valid && (!w_full || w_pop);
   assign w_drop   = in_valid && w_full && !w_pop;
   assign w_x_last = (x_q == c_X_LAST);
   assign w_y_last = (y_q == c_Y_LAST);

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      mem_d        = mem_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      count_d      = count_q;
      x_d          = x_q;
      y_d          = y_q;
      frame_done_d = 1'b0;
      overflow_d   = overflow_q | w_drop;

      if (w_push) begin
         mem_d[wr_ptr_q] = in_data;
         // Depth is a power of two, so natural pointer overflow is the wrap.
         wr_ptr_d        = wr_ptr_q + c_PW'(1);
      end

      if (w_pop) begin
         rd_ptr_d = rd_ptr_q + c_PW'(1);
      end

      unique case ({w_push, w_pop})
         2'b10:   count_d = count_q + c_CW'(1);
         2'b01:   count_d = count_q - c_CW'(1);
         default: count_d = count_q;
      endcase

      // Position tags follow the FIFO head, so they move only on handshakes.
      if (w_pop) begin
         if (w_x_last) begin
            x_d = '0;
            if (w_y_last) begin
               y_d          = '0;
               frame_done_d = 1'b1;
            end else begin
               y_d = y_q + c_YW'(1);
            end
         end else begin
            x_d = x_q + c_XW'(1);
         end
      end
   end

   // ------------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         count_q      <= '0;
         x_q          <= '0;
         y_q          <= '0;
         frame_done_q <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         mem_q        <= mem_d;
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         count_q      <= count_d;
         x_q          <= x_d;
         y_q          <= y_d;
         frame_done_q <= frame_done_d;
         overflow_q   <= overflow_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs (all derived from registered state)
   // ------------------------------------------------------------------------
   assign out_valid    = (count_q != '0);
   assign out_data     = out_valid ? mem_q[rd_ptr_q] : '0;
   assign stall        = (count_q >= c_STALL_AT);
   assign out_last_col = out_valid && w_x_last;
   assign out_last_row = out_valid && w_y_last;
   assign frame_done   = frame_done_q;
   assign overflow     = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_output_stream_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_stream_packer
// Description : Directed bench for output_stream_packer with a 4x2 frame and
//               a 4-entry FIFO. Covers streaming, row/frame markers, overflow,
//               full-FIFO pass-through, mid-frame reset and stall-gated flow.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_stream_packer;

   localparam int c_BW = 8;
   localparam int c_NF = 3;
   localparam int c_DW = c_BW * c_NF;

   logic            clk;
   logic            rst;
   logic            in_valid;
   logic [c_DW-1:0] in_data;
   logic            stall;
   logic            out_valid;
   logic            out_ready;
   logic [c_DW-1:0] out_data;
   logic            out_last_col;
   logic            out_last_row;
   logic            frame_done;
   logic            overflow;

   int n_checks;
   int n_pass;

   output_stream_packer #(
      .BITWIDTH  (c_BW),
      .NFMAPS    (c_NF),
      .OUT_X_DIM (4),
      .OUT_Y_DIM (2),
      .FIFO_DEPTH(4)
   ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .stall       (stall),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_last_col(out_last_col),
      .out_last_row(out_last_row),
      .frame_done  (frame_done),
      .overflow    (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are observed 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_valid"},    32'(out_valid),    32'd0);
      check_val({tag, "_stall"},    32'(stall),        32'd0);
      check_val({tag, "_lastcol"},  32'(out_last_col), 32'd0);
      check_val({tag, "_lastrow"},  32'(out_last_row), 32'd0);
      check_val({tag, "_fdone"},    32'(frame_done),   32'd0);
      check_val({tag, "_overflow"}, 32'(overflow),     32'd0);
      check_val({tag, "_data"},     32'(out_data),     32'd0);
   endtask

   // Stream one 4x2 frame with out_ready held high: each word is visible one
   // cycle after it is offered and is popped on the following edge.
   task automatic run_frame(input string tag, input logic [c_DW-1:0] base);
      out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         in_valid = 1'b1;
         in_data  = base + c_DW'(k);
         tick();
         check_val({tag, "_valid"},   32'(out_valid),    32'd1);
         check_val({tag, "_data"},    32'(out_data),     32'(base + c_DW'(k)));
         check_val({tag, "_lastcol"}, 32'(out_last_col), (k % 4 == 3) ? 32'd1 : 32'd0);
         check_val({tag, "_lastrow"}, 32'(out_last_row), (k >= 4) ? 32'd1 : 32'd0);
         check_val({tag, "_fdone0"},  32'(frame_done),   32'd0);
      end
      in_valid = 1'b0;
      tick();
      check_val({tag, "_fdone1"},  32'(frame_done), 32'd1);
      check_val({tag, "_empty"},   32'(out_valid),  32'd0);
      tick();
      check_val({tag, "_fdone_p"}, 32'(frame_done), 32'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      logic [c_DW-1:0] expq[$];
      logic [c_DW-1:0] exp_word;
      int              sent;
      int              got;
      int              stall_seen;

      n_checks  = 0;
      n_pass    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      tick();
      tick();
      check_reset_outputs("rst0");
      rst = 1'b0;

      // ---- Basic streaming, markers and frame_done --------------------------
      run_frame("s1", 24'hA00000);

      // ---- Fill, stall threshold, drop when full, ordered drain -------------
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 24'h0000AA; tick();
      check_val("s2_validA", 32'(out_valid), 32'd1);
      check_val("s2_dataA",  32'(out_data),  32'h0000AA);
      check_val("s2_stall1", 32'(stall),     32'd0);
      in_data   = 24'h0000BB; tick();
      check_val("s2_stall2", 32'(stall),     32'd0);
      in_data   = 24'h0000CC; tick();
      check_val("s2_stall3", 32'(stall),     32'd1);
      in_data   = 24'h0000DD; tick();
      check_val("s2_stall4", 32'(stall),     32'd1);
      check_val("s2_ovf4",   32'(overflow),  32'd0);
      in_data   = 24'h0000EE; tick();
      check_val("s2_ovf5",   32'(overflow),  32'd1);
      check_val("s2_hold",   32'(out_data),  32'h0000AA);
      check_val("s2_holdlc", 32'(out_last_col), 32'd0);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check_val("s2_dataB",  32'(out_data),  32'h0000BB);
      tick();
      check_val("s2_dataC",  32'(out_data),  32'h0000CC);
      tick();
      check_val("s2_dataD",  32'(out_data),  32'h0000DD);
      check_val("s2_lcD",    32'(out_last_col), 32'd1);
      tick();
      check_val("s2_empty",  32'(out_valid), 32'd0);
      check_val("s2_ovfst",  32'(overflow),  32'd1);

      // ---- Full FIFO with simultaneous push and pop -------------------------
      do_reset();
      check_val("s3_ovfclr", 32'(overflow), 32'd0);
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
         in_data = 24'hF00000 + c_DW'(k);
         tick();
      end
      check_val("s3_full_stall", 32'(stall), 32'd1);
      in_data   = 24'hF00004;
      out_ready = 1'b1;
      tick();
      check_val("s3_dataF1", 32'(out_data), 32'hF00001);
      check_val("s3_ovf0",   32'(overflow), 32'd0);
      check_val("s3_stall",  32'(stall),    32'd1);
      // Still full after push+pop: one more word without a pop must be lost.
      in_data   = 24'hF00005;
      out_ready = 1'b0;
      tick();
      check_val("s3_ovf1",   32'(overflow), 32'd1);
      check_val("s3_holdF1", 32'(out_data), 32'hF00001);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      for (int k = 2; k < 5; k++) begin
         tick();
         check_val("s3_drain", 32'(out_data), 32'(24'hF00000 + c_DW'(k)));
      end
      tick();
      check_val("s3_empty", 32'(out_valid), 32'd0);

      // ---- Mid-frame reset --------------------------------------------------
      do_reset();
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int k = 0; k < 3; k++) begin
         in_data = 24'h500000 + c_DW'(k);
         tick();
      end
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      for (int k = 0; k < 5; k++) begin
         in_data = 24'h600000 + c_DW'(k);
         tick();
      end
      check_val("s4_ovf_pre", 32'(overflow), 32'd1);
      rst       = 1'b1;
      out_ready = 1'b1;
      tick();
      check_reset_outputs("s4_rst");
      rst      = 1'b0;
      in_valid = 1'b0;
      run_frame("s4", 24'h700000);

      // ---- Stall-gated producer, toggling consumer --------------------------
      do_reset();
      sent       = 0;
      got        = 0;
      stall_seen = 0;
      out_ready  = 1'b1;
      for (int c = 0; c < 300 && got < 20; c++) begin
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               check_val("s5_spurious", 32'(out_valid), 32'd0);
            end else begin
               exp_word = expq.pop_front();
               check_val("s5_data", 32'(out_data), 32'(exp_word));
            end
            got++;
         end
         if (stall) stall_seen = 1;
         in_valid = (sent < 20) && !stall;
         if (in_valid) begin
            in_data = 24'h900000 + c_DW'(sent);
            expq.push_back(in_data);
            sent++;
         end
         tick();
         out_ready = ~out_ready;
      end
      in_valid = 1'b0;
      check_val("s5_count",    32'(got),        32'd20);
      check_val("s5_overflow", 32'(overflow),   32'd0);
      check_val("s5_stalled",  32'(stall_seen), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
